// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU with per-transaction lane width (8/16/32/DATA_W) and valid/ready flow control.
// Optional feature: define SIMD_ALU_SAT_EN for unsigned saturating add (op 9) and subtract (op 10).
module simd_alu_pipe #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OPC_W-1:0]  in_op,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic              out_ovf
);

  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_CEQ = OPC_W'(8);
`ifdef SIMD_ALU_SAT_EN
  localparam logic [OPC_W-1:0] OP_SADD = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_SSUB = OPC_W'(10);
`endif

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_adv;
  logic              s2_adv;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [OPC_W-1:0]  s1_op;
  logic [1:0]        s1_mode;

  logic [DATA_W-1:0] mode_res [4];
  logic [3:0]        mode_ovf;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // One lane-array per supported lane width; the S1 mode picks which array drives S2.
  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned LW = (m == 0) ? 8 : (m == 1) ? 16 : (m == 2) ? 32 : DATA_W;
    localparam int unsigned NL = DATA_W / LW;
    localparam int unsigned SW = $clog2(LW);

    logic [DATA_W-1:0] res;
    logic [NL-1:0]     ovf;

    for (genvar i = 0; i < NL; i++) begin : g_lane
      logic [LW-1:0] a;
      logic [LW-1:0] b;
      logic [LW-1:0] r;
      logic [LW:0]   sum;
      logic          o;

      assign a   = s1_a[i*LW +: LW];
      assign b   = s1_b[i*LW +: LW];
      assign sum = {1'b0, a} + {1'b0, b};

      always_comb begin
        r = a;
        o = 1'b0;
        case (s1_op)
          OP_SUB: begin r = a - b; o = (a < b); end
          OP_ADD: begin r = sum[LW-1:0]; o = sum[LW]; end
          OP_AND: r = a & b;
          OP_OR:  r = a | b;
          OP_XOR: r = a ^ b;
          OP_SHL: r = a << b[SW-1:0];
          OP_SHR: r = a >> b[SW-1:0];
          OP_MUL: r = a * b;
          OP_CEQ: r = (a == b) ? '1 : '0;
`ifdef SIMD_ALU_SAT_EN
          OP_SADD: begin r = sum[LW] ? '1 : sum[LW-1:0]; o = sum[LW]; end
          OP_SSUB: begin r = (a < b) ? '0 : a - b; o = (a < b); end
`endif
          default: r = a;
        endcase
      end

      assign res[i*LW +: LW] = r;
      assign ovf[i]          = o;
    end

    assign mode_res[m] = res;
    assign mode_ovf[m] = |ovf;
  end

  assign alu_res = mode_res[s1_mode];
  assign alu_ovf = mode_ovf[s1_mode];

  // S1 captures operands; S2 holds the result while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_mode  <= '0;
      out_data <= '0;
      out_zero <= 1'b1;
      out_ovf  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= in_a;
          s1_b    <= in_b;
          s1_op   <= in_op;
          s1_mode <= in_mode;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= alu_res;
          out_zero <= (alu_res == '0);
          out_ovf  <= alu_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe: directed vectors queue expected results, a monitor checks each output.
module tb_simd_alu_pipe;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned OPC_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              z;
    logic              o;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [OPC_W-1:0]  in_op;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_zero;
  logic              out_ovf;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  simd_alu_pipe #(.DATA_W(DATA_W), .OPC_W(OPC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [OPC_W-1:0] op, input logic [1:0] mode,
                      input logic [DATA_W-1:0] ed, input logic eo);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_mode = mode;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck low for op %0d", op);
    end else begin
      e.d = ed; e.z = (ed == '0); e.o = eo;
      q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    end
  endtask

  // Monitor: pop on every output transfer, and hold the head value during stalls.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected no output", out_data);
      end else if (out_ready) begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_zero", DATA_W'(out_zero), DATA_W'(e.z));
        chk("out_ovf", DATA_W'(out_ovf), DATA_W'(e.o));
      end else begin
        chk("stall_data", out_data, q[0].d);
      end
    end
  end

  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_mode = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("rst_out_zero", DATA_W'(out_zero), DATA_W'(1));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Halfword add: lane 0 carries out, lane 1 unaffected; also check latency.
    send(128'h0001_FFFF, 128'h0001_0001, 4'd1, 2'b01, 128'h0002_0000, 1'b1);
    chk("lat_t1_idle", DATA_W'(out_valid), DATA_W'(0));
    @(posedge clk); #1;
    chk("lat_t2_valid", DATA_W'(out_valid), DATA_W'(1));
    drain();

    // Word multiply, shift right, then back-to-back varied modes/opcodes.
    send(128'd10000, 128'd500, 4'd7, 2'b10, 128'd5000000, 1'b0);
    send(128'd10000, 128'd3, 4'd6, 2'b10, 128'd1250, 1'b0);
    cmp_a = 128'h0123456789ABCDEF_FEDCBA9876543210;
    cmp_b = 128'h0123456789ABCDEF_FEDCBA9800543210;
    send(cmp_a, cmp_b, 4'd8, 2'b00, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h00FF_FFFF}, 1'b0);
    send(128'h05, 128'h07, 4'd0, 2'b00, 128'hFE, 1'b1);
    send(128'hF0, 128'h0F, 4'd2, 2'b00, 128'h0, 1'b0);
    send({128{1'b1}}, 128'h1, 4'd1, 2'b11, 128'h0, 1'b1);
    send(128'h0001, 128'h0011, 4'd5, 2'b01, 128'h0002, 1'b0);
    send(128'hA5, 128'h5A, 4'd4, 2'b10, 128'hFF, 1'b0);
    send(128'hA0, 128'h0C, 4'd3, 2'b00, 128'hAC, 1'b0);
    send(128'h1234, 128'h5678, 4'd15, 2'b01, 128'h1234, 1'b0);
`ifdef SIMD_ALU_SAT_EN
    send(128'hF0, 128'h20, 4'd9, 2'b00, 128'hFF, 1'b1);
    send(128'h10, 128'h20, 4'd10, 2'b00, 128'h00, 1'b1);
`else
    send(128'hF0, 128'h20, 4'd9, 2'b00, 128'hF0, 1'b0);
    send(128'h10, 128'h20, 4'd10, 2'b00, 128'h10, 1'b0);
`endif
    drain();

    // Back-pressure: 4-deep stream with out_ready low for 3 edges.
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(DATA_W'(i + 1), 128'd100, 4'd1, 2'b10, DATA_W'(i + 101), 1'b0);
      end
      begin
        @(posedge clk); #2 out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("bp_in_ready_low", DATA_W'(in_ready), DATA_W'(0));
        chk("bp_out_valid", DATA_W'(out_valid), DATA_W'(1));
        @(posedge clk); #2 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full: discard in-flight work.
    out_ready = 1'b0;
    send(128'h11, 128'h22, 4'd1, 2'b00, 128'h33, 1'b0);
    send(128'h44, 128'h55, 4'd1, 2'b00, 128'h99, 1'b0);
    @(negedge clk);
    chk("full_in_ready", DATA_W'(in_ready), DATA_W'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("mid_rst_out_zero", DATA_W'(out_zero), DATA_W'(1));
    chk("mid_rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
    q.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(128'h0102_0304, 128'h0101_0101, 4'd0, 2'b00, 128'h0001_0203, 1'b0);
    chk("post_rst_t1_idle", DATA_W'(out_valid), DATA_W'(0));
    @(posedge clk); #1;
    chk("post_rst_t2_valid", DATA_W'(out_valid), DATA_W'(1));
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_alu_pipe.md
# simd_alu_pipe

Pipelined, parametrised SIMD ALU for the SPU datapath. It accepts one operand pair per cycle under a valid/ready handshake. Each operation is applied independently per lane, with the lane width selectable per transaction (byte, halfword, word or full width). It produces a registered result, a zero flag and an overflow flag two cycles later. It replaces the single-cycle combinational halfword/word ALU at the execute stage and supports back-pressure from the writeback stage.

## Interface
- DATA_W, 128, operand/result width; multiple of 32, minimum 32
- OPC_W, 4, opcode width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block accepts the operand pair this cycle
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_op  input  OPC_W  operation code
- in_mode  input  2  lane width: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = DATA_W
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  DATA_W  lane-wise result
- out_zero  output  1  out_data == 0
- out_ovf  output  1  any lane carried out (add) or borrowed (sub)

## Operation
- Lanes: L = lane width from in_mode; N = DATA_W/L. Lane i occupies bits [i*L+L-1 : i*L]. No carry, borrow or shift ever crosses a lane boundary.
- Opcodes, each per lane, all unsigned:
  - 0: a−b, modulo 2^L
  - 1: a+b, modulo 2^L
  - 2: a&b
  - 3: a|b
  - 4: a^b
  - 5: a<<s, where s = low log2(L) bits of the b lane; zero fill
  - 6: a>>s, logical; s as for opcode 5
  - 7: a*b, low L bits of the product
  - 8: lane all-ones if a==b, else all-zeros
  - any other code: result = a (passthrough). Opcodes 9/10 fall here unless the configuration macro is defined.
- out_ovf: OR over lanes of carry-out (op 1) or borrow, i.e. a<b (op 0). Always 0 for every other opcode.
- out_zero: set when the final out_data is all zeros, for every opcode.
- Pipeline stages:
  - S1 registers in_a, in_b, in_op, in_mode.
  - S2 registers out_data, out_zero and out_ovf, computed combinationally from S1.
  - Each stage has a valid bit.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv, a combinational function of state and out_ready.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready, where out_valid = s2_valid.
- While stalled (out_valid & !out_ready), out_data, out_zero and out_ovf hold stable, and S1 holds if it is valid.
- in_* are ignored when in_valid is low. A stage with its valid bit low never produces out_valid.

## Timing
- Reset (asynchronous, immediate): s1_valid = s2_valid = 0. out_valid = 0, out_data = 0, out_zero = 1, out_ovf = 0. in_ready = 1 while rst is high and after release.
- Latency: an accepted input in cycle t appears with out_valid high in cycle t+2 if the output is not stalled.
- Throughput: one transaction per cycle while out_ready stays high.
- Maximum occupancy is 2. With both stages full and out_ready low, in_ready = 0.
- Simultaneous input and output transfer in the same cycle: both occur. No bubble, no drop, no duplicate.
- Reset asserted mid-operation discards both in-flight transactions. No output is produced for them.
- in_mode and in_op are captured per transaction. Changing them back-to-back needs no idle cycle.

## Configuration
- SIMD_ALU_SAT_EN defined:
  - Opcode 9 is unsigned saturating add; lanes clamp to 2^L−1.
  - Opcode 10 is unsigned saturating subtract; lanes clamp to 0.
  - For opcodes 9 and 10, out_ovf = OR over lanes of "clamp occurred".
- SIMD_ALU_SAT_EN undefined: opcodes 9 and 10 are passthrough (result = a, out_ovf = 0). No saturation logic is synthesised.

## Test plan
- Add, halfword: mode 01, a = 0x...0001_FFFF, b = 0x...0001_0001, op 1. Required: low lanes 0x0002_0000, out_ovf = 1, no carry into lane 2, out_valid at t+2.
- Word multiply and shift:
  - mode 10, op 7, a = 10000, b = 500: lane 0 = 5000000, other lanes 0.
  - op 6, a = 10000, b = 3: lane 0 = 1250.
- Compare, byte lanes: mode 00, op 8, a = b except byte 3. Required: out_data = all-ones except byte 3 = 0x00, out_zero = 0.
- Back-pressure: stream 4 transactions with out_ready low for 3 cycles mid-stream. Required: in_ready drops when 2 are held, outputs stay stable, all 4 arrive in order with no loss or duplication.
- Reset mid-flight: assert rst with both stages valid. Required: out_valid = 0 and out_zero = 1 immediately, nothing emitted after release, next input emerges at t+2.
- SIMD_ALU_SAT_EN build: mode 00, op 9, a = 0xF0, b = 0x20 gives 0xFF with out_ovf = 1. Without the macro, the same stimulus gives 0xF0 with out_ovf = 0.
